// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//   Pipeline stage sitting directly after execute. Holds one instruction,
//   performs RV32I loads/stores over a req/gnt/rvalid data-memory port and
//   presents a registered writeback beat downstream.
//
//   Optional feature macro: MEMORY_MISALIGN_TRAP_EN
//     defined   : adds misalign_o; misaligned half/word accesses skip memory
//                 and emit a non-writing beat flagged with misalign_o.
//     undefined : misaligned accesses are issued with truncated byte enables.
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     valid_i / ready_o     execute -> memory handshake
//     pc_i, alu_res_i,
//     rs2_i, rd_i,
//     funct3_i, opcode_i    instruction fields from execute
//     valid_o / ready_i     memory -> writeback handshake
//     wb_data_o, rd_o,
//     regwen_o, pc_o        registered writeback beat
//     dmem_*                data-memory request/response port
//     misalign_o            misalignment flag (only with the macro defined)
// ---------------------------------------------------------------------------
module memory_stage #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [AWIDTH-1:0] pc_i,
   input  logic [DWIDTH-1:0] alu_res_i,
   input  logic [DWIDTH-1:0] rs2_i,
   input  logic [4:0]        rd_i,
   input  logic [2:0]        funct3_i,
   input  logic [6:0]        opcode_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DWIDTH-1:0] wb_data_o,
   output logic [4:0]        rd_o,
   output logic              regwen_o,
   output logic [AWIDTH-1:0] pc_o,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [AWIDTH-1:0] dmem_addr_o,
   output logic [DWIDTH-1:0] dmem_wdata_o,
   output logic [3:0]        dmem_be_o,
   input  logic              dmem_gnt_i,
   input  logic              dmem_rvalid_i,
   input  logic [DWIDTH-1:0] dmem_rdata_i
`ifdef MEMORY_MISALIGN_TRAP_EN
   ,
   output logic              misalign_o
`endif
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   state_t            state_reg;
   logic [AWIDTH-1:0] pc_reg;
   logic [DWIDTH-1:0] alu_reg;
   logic [4:0]        rd_reg;
   logic [2:0]        funct3_reg;

   // ------------------------------------------------------------------
   // Input-side decode (evaluated on the accepting cycle)
   // ------------------------------------------------------------------
   logic              accept;
   logic              is_load_in;
   logic              is_store_in;
   logic              is_mem_in;
   logic              trap_in;
   logic [1:0]        off_in;
   size_t             size_in;
   logic [3:0]        be_in;
   logic [DWIDTH-1:0] wdata_in;
   logic [DWIDTH-1:0] byte_rep;
   logic [DWIDTH-1:0] half_rep;
   logic [DWIDTH-1:0] wb_direct_in;
   logic              regwen_in;
   logic [AWIDTH-1:0] addr_in;

   assign ready_o     = (state_reg == S_IDLE) && (!valid_o || ready_i);
   assign accept      = valid_i && ready_o;
   assign is_load_in  = (opcode_i == OP_LOAD);
   assign is_store_in = (opcode_i == OP_STORE);
   assign is_mem_in   = is_load_in || is_store_in;
   assign off_in      = alu_res_i[1:0];
   assign addr_in     = {alu_res_i[AWIDTH-1:2], 2'b00};
   assign regwen_in   = (rd_i != 5'd0) && (opcode_i != OP_STORE) && (opcode_i != OP_BRANCH);
   assign wb_direct_in = ((opcode_i == OP_JAL) || (opcode_i == OP_JALR)) ?
                         DWIDTH'(pc_i + AWIDTH'(4)) : alu_res_i;

   // Store data replicated across every lane so the byte enables alone
   // select which bytes memory takes.
   genvar gi;
   generate
      for (gi = 0; gi < DWIDTH/8; gi++) begin : g_byte_rep
         assign byte_rep[gi*8 +: 8] = rs2_i[7:0];
      end
      for (gi = 0; gi < DWIDTH/16; gi++) begin : g_half_rep
         assign half_rep[gi*16 +: 16] = rs2_i[15:0];
      end
   endgenerate

   // Access size; funct3 codes that are not legal for the opcode fall back
   // to a word access.
   always_comb begin
      size_in = SZ_W;
      case (funct3_i)
         3'b000:  size_in = SZ_B;
         3'b001:  size_in = SZ_H;
         3'b100:  size_in = is_load_in ? SZ_B : SZ_W;
         3'b101:  size_in = is_load_in ? SZ_H : SZ_W;
         default: size_in = SZ_W;
      endcase
   end

   // Shifting inside a 4-bit context drops lanes past byte 3, which gives
   // the truncated enables of a misaligned half access.
   always_comb begin
      be_in    = 4'b1111;
      wdata_in = rs2_i;
      case (size_in)
         SZ_B: begin
            be_in    = 4'b0001 << off_in;
            wdata_in = byte_rep;
         end
         SZ_H: begin
            be_in    = 4'b0011 << off_in;
            wdata_in = half_rep;
         end
         default: begin
            be_in    = 4'b1111;
            wdata_in = rs2_i;
         end
      endcase
   end

`ifdef MEMORY_MISALIGN_TRAP_EN
   logic misaligned_in;
   assign misaligned_in = ((size_in == SZ_H) && off_in[0]) ||
                          ((size_in == SZ_W) && (off_in != 2'b00));
   assign trap_in = is_mem_in && misaligned_in;
`else
   assign trap_in = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Load extraction: bytes shift down by the offset with zero fill, then
   // get sign/zero extended according to the latched funct3.
   // ------------------------------------------------------------------
   logic [DWIDTH-1:0] load_sh;
   logic [DWIDTH-1:0] load_ext;

   assign load_sh = dmem_rdata_i >> {alu_reg[1:0], 3'b000};

   always_comb begin
      load_ext = load_sh;
      case (funct3_reg)
         3'b000:  load_ext = {{(DWIDTH-8){load_sh[7]}}, load_sh[7:0]};
         3'b100:  load_ext = {{(DWIDTH-8){1'b0}}, load_sh[7:0]};
         3'b001:  load_ext = {{(DWIDTH-16){load_sh[15]}}, load_sh[15:0]};
         3'b101:  load_ext = {{(DWIDTH-16){1'b0}}, load_sh[15:0]};
         default: load_ext = load_sh;
      endcase
   end

   // ------------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         pc_reg       <= '0;
         alu_reg      <= '0;
         rd_reg       <= '0;
         funct3_reg   <= '0;
         valid_o      <= 1'b0;
         wb_data_o    <= '0;
         rd_o         <= '0;
         regwen_o     <= 1'b0;
         pc_o         <= '0;
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_wdata_o <= '0;
         dmem_be_o    <= '0;
`ifdef MEMORY_MISALIGN_TRAP_EN
         misalign_o   <= 1'b0;
`endif
      end else begin
         // A consumed beat drops; any branch below that emits a new beat
         // overrides this.
         if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end

         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  pc_reg     <= pc_i;
                  alu_reg    <= alu_res_i;
                  rd_reg     <= rd_i;
                  funct3_reg <= funct3_i;
                  if (is_mem_in && !trap_in) begin
                     state_reg    <= S_REQ;
                     dmem_req_o   <= 1'b1;
                     dmem_we_o    <= is_store_in;
                     dmem_addr_o  <= addr_in;
                     dmem_be_o    <= be_in;
                     dmem_wdata_o <= wdata_in;
                  end else begin
                     valid_o   <= 1'b1;
                     wb_data_o <= wb_direct_in;
                     rd_o      <= rd_i;
                     pc_o      <= pc_i;
                     regwen_o  <= regwen_in && !trap_in;
`ifdef MEMORY_MISALIGN_TRAP_EN
                     misalign_o <= trap_in;
`endif
                  end
               end
            end

            S_REQ: begin
               if (dmem_gnt_i) begin
                  dmem_req_o <= 1'b0;
                  dmem_we_o  <= 1'b0;
                  if (dmem_we_o) begin
                     state_reg <= S_IDLE;
                     valid_o   <= 1'b1;
                     wb_data_o <= alu_reg;
                     rd_o      <= rd_reg;
                     pc_o      <= pc_reg;
                     regwen_o  <= 1'b0;
`ifdef MEMORY_MISALIGN_TRAP_EN
                     misalign_o <= 1'b0;
`endif
                  end else begin
                     state_reg <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               if (dmem_rvalid_i) begin
                  state_reg <= S_IDLE;
                  valid_o   <= 1'b1;
                  wb_data_o <= load_ext;
                  rd_o      <= rd_reg;
                  pc_o      <= pc_reg;
                  regwen_o  <= (rd_reg != 5'd0);
`ifdef MEMORY_MISALIGN_TRAP_EN
                  misalign_o <= 1'b0;
`endif
               end
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   logic        clk;
   logic        reset;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] pc_i;
   logic [31:0] alu_res_i;
   logic [31:0] rs2_i;
   logic [4:0]  rd_i;
   logic [2:0]  funct3_i;
   logic [6:0]  opcode_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] wb_data_o;
   logic [4:0]  rd_o;
   logic        regwen_o;
   logic [31:0] pc_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
`ifdef MEMORY_MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   int tests_run;
   int tests_failed;

   memory_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .pc_i          (pc_i),
      .alu_res_i     (alu_res_i),
      .rs2_i         (rs2_i),
      .rd_i          (rd_i),
      .funct3_i      (funct3_i),
      .opcode_i      (opcode_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .wb_data_o     (wb_data_o),
      .rd_o          (rd_o),
      .regwen_o      (regwen_o),
      .pc_o          (pc_o),
      .dmem_req_o    (dmem_req_o),
      .dmem_we_o     (dmem_we_o),
      .dmem_addr_o   (dmem_addr_o),
      .dmem_wdata_o  (dmem_wdata_o),
      .dmem_be_o     (dmem_be_o),
      .dmem_gnt_i    (dmem_gnt_i),
      .dmem_rvalid_i (dmem_rvalid_i),
      .dmem_rdata_i  (dmem_rdata_i)
`ifdef MEMORY_MISALIGN_TRAP_EN
      ,
      .misalign_o    (misalign_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and sample 1 ns after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
      valid_i   = 1'b1;
      opcode_i  = op;
      funct3_i  = f3;
      pc_i      = pc;
      alu_res_i = alu;
      rs2_i     = rs2;
      rd_i      = rd;
   endtask

   // Load with grant on the first request cycle and data on the next.
   task automatic mem_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_wb);
      issue(OP_LOAD, f3, 32'h0000_0400, addr, 32'h0, 5'd7);
      step();
      valid_i = 1'b0;
      check({tag, "_req"}, {31'd0, dmem_req_o}, 32'd1);
      check({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
      check({tag, "_be"}, {28'd0, dmem_be_o}, {28'd0, exp_be});
      dmem_gnt_i = 1'b1;
      step();
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = rdata;
      step();
      dmem_rvalid_i = 1'b0;
      check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
      check({tag, "_wb"}, wb_data_o, exp_wb);
      check({tag, "_regwen"}, {31'd0, regwen_o}, 32'd1);
      $display("[TB] %s addr=%h rdata=%h wb=%h", tag, addr, rdata, wb_data_o);
      step();
   endtask

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      reset         = 1'b1;
      valid_i       = 1'b0;
      pc_i          = '0;
      alu_res_i     = '0;
      rs2_i         = '0;
      rd_i          = '0;
      funct3_i      = '0;
      opcode_i      = '0;
      ready_i       = 1'b1;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b1;   // stale response during reset must be ignored
      dmem_rdata_i  = 32'hDEAD_BEEF;
      step();
      step();
      dmem_rvalid_i = 1'b0;

      // Reset state
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_req", {31'd0, dmem_req_o}, 32'd0);
      check("rst_we", {31'd0, dmem_we_o}, 32'd0);
      check("rst_be", {28'd0, dmem_be_o}, 32'd0);
      check("rst_regwen", {31'd0, regwen_o}, 32'd0);
      check("rst_wb", wb_data_o, 32'd0);
      check("rst_addr", dmem_addr_o, 32'd0);
      check("rst_ready", {31'd0, ready_o}, 32'd1);
      $display("[TB] reset state checked");
      reset = 1'b0;
      dmem_rvalid_i = 1'b1;   // rvalid in IDLE: no effect
      step();
      dmem_rvalid_i = 1'b0;
      check("idle_rvalid_ignored", {31'd0, valid_o}, 32'd0);

      // Pass-through ALU op, latency 1
      issue(OP_IMM, 3'b000, 32'h0000_0100, 32'h0000_1234, 32'h0, 5'd5);
      step();
      valid_i = 1'b0;
      check("pt_valid", {31'd0, valid_o}, 32'd1);
      check("pt_wb", wb_data_o, 32'h0000_1234);
      check("pt_regwen", {31'd0, regwen_o}, 32'd1);
      check("pt_rd", {27'd0, rd_o}, 32'd5);
      check("pt_pc", pc_o, 32'h0000_0100);
      check("pt_noreq", {31'd0, dmem_req_o}, 32'd0);
`ifdef MEMORY_MISALIGN_TRAP_EN
      check("pt_misalign", {31'd0, misalign_o}, 32'd0);
`endif
      $display("[TB] pass-through wb=%h", wb_data_o);
      step();
      check("pt_drop", {31'd0, valid_o}, 32'd0);

      // JAL writes back pc+4
      issue(OP_JAL, 3'b000, 32'h0000_0200, 32'h0000_DEAD, 32'h0, 5'd1);
      step();
      valid_i = 1'b0;
      check("jal_wb", wb_data_o, 32'h0000_0204);
      $display("[TB] jal wb=%h", wb_data_o);
      step();

      // Loads
      mem_load("lb",  3'b000, 32'h0000_1003, 32'h80FF_FFFF, 4'b1000, 32'hFFFF_FF80);
      mem_load("lbu", 3'b100, 32'h0000_1003, 32'h80FF_FFFF, 4'b1000, 32'h0000_0080);
      mem_load("lhu", 3'b101, 32'h0000_1002, 32'h80FF_FFFF, 4'b1100, 32'h0000_80FF);
      mem_load("lh",  3'b001, 32'h0000_1000, 32'h0000_8001, 4'b0011, 32'hFFFF_8001);
      mem_load("lw",  3'b010, 32'h0000_1000, 32'h1234_5678, 4'b1111, 32'h1234_5678);

      // SH with grant delayed 3 cycles
      issue(OP_STORE, 3'b001, 32'h0000_0500, 32'h0000_2002, 32'hABCD_1234, 5'd3);
      step();
      valid_i = 1'b0;
      check("sh_addr", dmem_addr_o, 32'h0000_2000);
      check("sh_be", {28'd0, dmem_be_o}, 32'h0000_000C);
      check("sh_wdata", dmem_wdata_o, 32'h1234_1234);
      check("sh_we", {31'd0, dmem_we_o}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         check("sh_stall_req", {31'd0, dmem_req_o}, 32'd1);
         check("sh_stall_addr", dmem_addr_o, 32'h0000_2000);
         check("sh_stall_be", {28'd0, dmem_be_o}, 32'h0000_000C);
         check("sh_stall_ready", {31'd0, ready_o}, 32'd0);
         check("sh_stall_valid", {31'd0, valid_o}, 32'd0);
         step();
      end
      check("sh_prgnt_req", {31'd0, dmem_req_o}, 32'd1);
      dmem_gnt_i = 1'b1;
      step();
      dmem_gnt_i = 1'b0;
      check("sh_valid", {31'd0, valid_o}, 32'd1);
      check("sh_regwen", {31'd0, regwen_o}, 32'd0);
      check("sh_wb", wb_data_o, 32'h0000_2002);
      check("sh_req_drop", {31'd0, dmem_req_o}, 32'd0);
      $display("[TB] sh addr=%h be=%b wdata=%h", dmem_addr_o, dmem_be_o, dmem_wdata_o);
      step();

      // SB lane placement
      issue(OP_STORE, 3'b000, 32'h0000_0600, 32'h0000_3001, 32'h0000_00A5, 5'd0);
      step();
      valid_i = 1'b0;
      check("sb_be", {28'd0, dmem_be_o}, 32'h0000_0002);
      check("sb_wdata", dmem_wdata_o, 32'hA5A5_A5A5);
      $display("[TB] sb be=%b wdata=%h", dmem_be_o, dmem_wdata_o);
      dmem_gnt_i = 1'b1;
      step();
      dmem_gnt_i = 1'b0;
      step();

      // Writeback back-pressure: beat held, next instruction waits
      ready_i = 1'b0;
      issue(OP_IMM, 3'b000, 32'h0000_0700, 32'h0000_0111, 32'h0, 5'd9);
      step();
      issue(OP_IMM, 3'b000, 32'h0000_0704, 32'h0000_0222, 32'h0, 5'd10);
      #1;
      check("bp_ready", {31'd0, ready_o}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         check("bp_valid_hold", {31'd0, valid_o}, 32'd1);
         check("bp_wb_hold", wb_data_o, 32'h0000_0111);
         check("bp_rd_hold", {27'd0, rd_o}, 32'd9);
      end
      ready_i = 1'b1;
      step();
      valid_i = 1'b0;
      check("bp_next_valid", {31'd0, valid_o}, 32'd1);
      check("bp_next_wb", wb_data_o, 32'h0000_0222);
      $display("[TB] backpressure released wb=%h", wb_data_o);
      step();
      check("bp_drop", {31'd0, valid_o}, 32'd0);

      // Reset while waiting for load data, then a stale rvalid
      issue(OP_LOAD, 3'b010, 32'h0000_0800, 32'h0000_4000, 32'h0, 5'd4);
      step();
      valid_i = 1'b0;
      dmem_gnt_i = 1'b1;
      step();
      dmem_gnt_i = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'h5555_AAAA;
      step();
      dmem_rvalid_i = 1'b0;
      check("rstw_valid", {31'd0, valid_o}, 32'd0);
      check("rstw_ready", {31'd0, ready_o}, 32'd1);
      check("rstw_req", {31'd0, dmem_req_o}, 32'd0);
      step();
      check("rstw_valid2", {31'd0, valid_o}, 32'd0);
      $display("[TB] reset during wait checked");

`ifdef MEMORY_MISALIGN_TRAP_EN
      // Misaligned LW traps without touching memory
      issue(OP_LOAD, 3'b010, 32'h0000_0900, 32'h0000_1002, 32'h0, 5'd6);
      #1;
      check("mis_ready", {31'd0, ready_o}, 32'd1);
      step();
      valid_i = 1'b0;
      check("mis_noreq", {31'd0, dmem_req_o}, 32'd0);
      check("mis_valid", {31'd0, valid_o}, 32'd1);
      check("mis_flag", {31'd0, misalign_o}, 32'd1);
      check("mis_regwen", {31'd0, regwen_o}, 32'd0);
      $display("[TB] misaligned lw trapped");
      step();
      check("mis_noreq2", {31'd0, dmem_req_o}, 32'd0);
      check("mis_drop", {31'd0, valid_o}, 32'd0);
`else
      // Misaligned LH without trapping: truncated enables, zero fill
      mem_load("lh_mis", 3'b001, 32'h0000_1003, 32'hAB00_0000, 4'b1000, 32'h0000_00AB);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
